// File: rtl/spi_slave_pkg.sv
// Shared constants, state encoding and small helpers for the SPI responder.
// The frame widths are the same values the SPI master uses for its width_16 option.
package spi_slave_pkg;

   localparam int SPI_W8  = 8;
   localparam int SPI_W16 = 16;

   typedef enum logic [1:0] {
      WAIT_DESEL = 2'd0,
      IDLE       = 2'd1,
      ACTIVE     = 2'd2
   } state_e;

   // Number of SCLK rises that make up one frame.
   function automatic logic [4:0] frame_len(input logic w16);
      return w16 ? 5'(SPI_W16) : 5'(SPI_W8);
   endfunction

   // Bit that goes out first: bit 15 of a 16-bit frame, bit 7 of an 8-bit frame.
   function automatic logic tx_msb(input logic [15:0] word, input logic w16);
      return w16 ? word[15] : word[7];
   endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI pin bundle between an external host (master modport) and this responder (slave modport).
interface spi_slave_if;

   logic spi_sclk;
   logic spi_cs_n;
   logic spi_mosi;
   logic spi_miso;
   logic spi_miso_oe;

   modport master (
      output spi_sclk,
      output spi_cs_n,
      output spi_mosi,
      input  spi_miso,
      input  spi_miso_oe
   );

   modport slave (
      input  spi_sclk,
      input  spi_cs_n,
      input  spi_mosi,
      output spi_miso,
      output spi_miso_oe
   );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, followed by one flop that
// yields single-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic raw_clk,
   input  logic reset,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Clearing to 0 means a chip select held low through reset reads as
   // still selected, which keeps the FSM parked until the host deselects.
   // NOTE: clocked state is written with <= so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge raw_clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     =  sync_out & ~prev_q;
   assign fall     = ~sync_out &  prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, 8- or 16-bit frames, pins oversampled on raw_clk.
// Received frames are handed to the register side through rx_ready/rx_ack.
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        raw_clk,
   input  logic        reset,
   spi_slave_if.slave  spi,
   input  logic        width_16,
   input  logic [15:0] data_tx,
   output logic [15:0] data_rx,
   output logic        rx_ready,
   input  logic        rx_ack,
   output logic        overrun,
   output logic        busy
);

   state_e state_q, state_d;

   logic sclk_rise, sclk_fall, sclk_level_unused;
   logic cs_sync, cs_rise, cs_fall;

   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   mosi_s;

   logic        w16_q;
   logic [15:0] tx_shift_q;
   logic [15:0] rx_shift_q;
   logic [4:0]  bit_cnt_q;
   logic        miso_q;
   logic        miso_oe;
   logic        frame_done;
   logic [15:0] tx_next;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
      .raw_clk  (raw_clk),
      .reset    (reset),
      .async_in (spi.spi_sclk),
      .sync_out (sclk_level_unused),
      .rise     (sclk_rise),
      .fall     (sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
      .raw_clk  (raw_clk),
      .reset    (reset),
      .async_in (spi.spi_cs_n),
      .sync_out (cs_sync),
      .rise     (cs_rise),
      .fall     (cs_fall)
   );

   // Same depth as the SCLK path, so data and clock stay aligned.
   always_ff @(posedge raw_clk) begin
      if (reset) mosi_sync_q <= '0;
      else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.spi_mosi};
   end
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   always_ff @(posedge raw_clk) begin
      if (reset) state_q <= WAIT_DESEL;
      else       state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WAIT_DESEL: if (cs_sync) state_d = IDLE;
         IDLE:       if (cs_fall) state_d = ACTIVE;
         ACTIVE:     if (cs_rise) state_d = IDLE;
         default:    state_d = WAIT_DESEL;
      endcase
   end

   always_comb begin
      busy    = (state_q == ACTIVE);
      miso_oe = (state_q == ACTIVE);
   end

   assign spi.spi_miso    = miso_q;
   assign spi.spi_miso_oe = miso_oe;

   assign frame_done = (state_q == ACTIVE) && (bit_cnt_q == frame_len(w16_q));
   assign tx_next    = tx_shift_q << 1;

   // Shift datapath. A fall with the counter at zero only re-presents the MSB:
   // at frame start that is a no-op, after a reload it exposes the new word.
   always_ff @(posedge raw_clk) begin
      if (reset) begin
         w16_q      <= 1'b0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         bit_cnt_q  <= '0;
         miso_q     <= 1'b0;
      end else if (state_q == IDLE) begin
         if (cs_fall) begin
            w16_q      <= width_16;
            tx_shift_q <= data_tx;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            miso_q     <= tx_msb(data_tx, width_16);
         end
      end else if (state_q == ACTIVE) begin
         if (cs_rise) begin
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
         end else if (frame_done) begin
            tx_shift_q <= data_tx;
            bit_cnt_q  <= '0;
         end else if (sclk_rise) begin
            rx_shift_q <= {rx_shift_q[14:0], mosi_s};
            bit_cnt_q  <= bit_cnt_q + 5'd1;
         end else if (sclk_fall) begin
            if (bit_cnt_q == '0) begin
               miso_q <= tx_msb(tx_shift_q, w16_q);
            end else begin
               tx_shift_q <= tx_next;
               miso_q     <= tx_msb(tx_next, w16_q);
            end
         end
      end
   end

   // Register-side handshake; a completion outranks a same-cycle acknowledge.
   always_ff @(posedge raw_clk) begin
      if (reset) begin
         data_rx  <= '0;
         rx_ready <= 1'b0;
         overrun  <= 1'b0;
      end else if (frame_done) begin
         data_rx  <= w16_q ? rx_shift_q : {8'h00, rx_shift_q[7:0]};
         rx_ready <= 1'b1;
         overrun  <= rx_ack ? 1'b0 : (overrun | rx_ready);
      end else if (rx_ack) begin
         rx_ready <= 1'b0;
         overrun  <= 1'b0;
      end
   end

endmodule
